// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: conditions the raw lines, requests to send,
// shifts 8 data bits + odd parity + stop on device clock falls, then checks the device ack.
module ps2_host_tx #(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int FILTER     = 8,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);
    localparam int INHIBIT_CYC = CLK_FREQ / 10000;
    localparam int REQ_CYC     = CLK_FREQ / 1_000_000;
    localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int TW_MIN      = $clog2(TIMEOUT_CYC + 1);
    localparam int TW          = (TW_MIN > 19) ? TW_MIN : 19;
    localparam int CW_I        = $clog2(INHIBIT_CYC + 1);
    localparam int CW_R        = $clog2(REQ_CYC + 1);
    localparam int CW          = (CW_I > CW_R) ? CW_I : CW_R;
    localparam int FW          = $clog2(FILTER + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic            clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
    logic [FW-1:0]   clk_fcnt_q, clk_fcnt_d, dat_fcnt_q, dat_fcnt_d;
    logic            clk_prev_q, clk_prev_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TW-1:0]   tout_q, tout_d, tout_inc;
    logic            clk_out_q, clk_out_d, dat_out_q, dat_out_d;
    logic            nack_q, nack_d, done_q, done_d, err_q, err_d;
    logic            clk_fall, timeout_hit;

    // State register: every flop, async reset to the released/idle values.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_fcnt_q <= '0;
            dat_fcnt_q <= '0;
            clk_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '1;
            tout_q     <= '0;
            clk_out_q  <= 1'b1;
            dat_out_q  <= 1'b1;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_filt_q <= clk_filt_d;
            dat_filt_q <= dat_filt_d;
            clk_fcnt_q <= clk_fcnt_d;
            dat_fcnt_q <= dat_fcnt_d;
            clk_prev_q <= clk_prev_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tout_q     <= tout_d;
            clk_out_q  <= clk_out_d;
            dat_out_q  <= dat_out_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Line conditioning: the filtered value flips only after FILTER differing samples in a row.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_filt_d = clk_filt_q;
        dat_filt_d = dat_filt_q;
        clk_fcnt_d = '0;
        dat_fcnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_fcnt_q == FW'(FILTER - 1)) clk_filt_d = clk_sync_q[1];
            else                               clk_fcnt_d = clk_fcnt_q + FW'(1);
        end
        if (dat_sync_q[1] != dat_filt_q) begin
            if (dat_fcnt_q == FW'(FILTER - 1)) dat_filt_d = dat_sync_q[1];
            else                               dat_fcnt_d = dat_fcnt_q + FW'(1);
        end
        clk_prev_d = clk_filt_q;
    end

    assign clk_fall    = clk_prev_q & ~clk_filt_q;
    assign tout_inc    = (tout_q == TW'(TIMEOUT_CYC)) ? tout_q : tout_q + TW'(1);
    assign timeout_hit = (tout_q >= TW'(TIMEOUT_CYC - 1));

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tout_d    = tout_q;
        clk_out_d = clk_out_q;
        dat_out_d = dat_out_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_out_d = 1'b1;
                dat_out_d = 1'b1;
                if (tx_valid) begin
                    // Stop bit sits at index 9 so one index covers the whole frame.
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
                    cnt_d     = '0;
                    dat_out_d = 1'b0;
                    state_d   = S_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REQ: begin
                if (cnt_q == CW'(REQ_CYC - 1)) begin
                    clk_out_d = 1'b1;
                    bit_cnt_d = '0;
                    tout_d    = '0;
                    state_d   = S_BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BITS: begin
                tout_d = tout_inc;
                if (clk_fall) begin
                    dat_out_d = shift_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) state_d = S_ACK;
                end
            end
            S_ACK: begin
                tout_d = tout_inc;
                if (clk_fall) begin
                    nack_d  = dat_filt_q;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                tout_d = tout_inc;
                if (clk_filt_q && dat_filt_q) begin
                    state_d = S_IDLE;
                    done_d  = ~nack_q;
                    err_d   = nack_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Timeout overrides a same-cycle normal completion.
        if ((state_q == S_BITS || state_q == S_ACK || state_q == S_WAIT_IDLE) && timeout_hit) begin
            state_d   = S_IDLE;
            clk_out_d = 1'b1;
            dat_out_d = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        tx_ready    = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        ps2_clk_out = clk_out_q;
        ps2_dat_out = dat_out_q;
        tx_done     = done_q;
        tx_error    = err_q;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model, a scripted PS/2 device, and a
// scoreboard of expected frame bits and expected done/error outcomes.
module tb_ps2_host_tx;
  localparam int CLK_FREQ    = 28_000_000;
  localparam int FILTER      = 8;
  localparam int TIMEOUT_MS  = 1;
  localparam int INHIBIT_CYC = CLK_FREQ / 10000;
  localparam int REQ_CYC     = CLK_FREQ / 1_000_000;
  localparam int TIMEOUT_CYC = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int H           = 30;
  localparam int W           = 2;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_NOCLK  = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RESET  = 4;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_out, ps2_dat_out;
  logic       tx_ready, tx_done, tx_error, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:0]   bit_q[$];
  logic [W-1:0] exp_q[$];

  // Wired-AND bus: either side can pull a line low.
  assign ps2_clk_in = ps2_clk_out & dev_clk;
  assign ps2_dat_in = ps2_dat_out & dev_dat;

  ps2_host_tx #(
    .CLK_FREQ(CLK_FREQ),
    .FILTER(FILTER),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk28(clk28),
    .rst_n(rst_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_out(ps2_clk_out),
    .ps2_dat_out(ps2_dat_out),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .busy(busy)
  );

  // Clock / reset block
  always #5 clk28 = ~clk28;

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: outcome pulses pop the expected outcome queue.
  always @(negedge clk28) begin
    if (tx_done || tx_error) begin
      if (exp_q.size() == 0) check("unexpected_pulse", {tx_error, tx_done}, 2'b00);
      else                   check("outcome", {tx_error, tx_done}, exp_q.pop_front());
    end
  end

  // Driver + device model for one transfer.
  task automatic send(input logic [7:0] d, input int mode);
    int cnt;
    logic [0:0] b;
    cnt = 0;
    while (!tx_ready && cnt < 5000) begin
      @(negedge clk28);
      cnt++;
    end
    check("ready_before", tx_ready, 1);
    if (mode != M_NOCLK) begin
      for (int i = 0; i < 8; i++) begin
        b = d[i];
        bit_q.push_back(b);
      end
      b = ~^d;
      bit_q.push_back(b);
      bit_q.push_back(1'b1);
    end
    if (mode == M_ACK || mode == M_GLITCH) exp_q.push_back(2'b01);
    if (mode == M_NACK || mode == M_NOCLK) exp_q.push_back(2'b10);

    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk28);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
    check("accept_lines", {tx_ready, busy, ps2_clk_out, ps2_dat_out}, 4'b0101);

    cnt = 1;
    while (cnt < INHIBIT_CYC + 100) begin
      @(negedge clk28);
      if (!ps2_dat_out) break;
      cnt++;
    end
    check("inhibit_cycles", cnt, INHIBIT_CYC);
    check("start_clk_low", ps2_clk_out, 0);

    cnt = 1;
    while (cnt < REQ_CYC + 100) begin
      @(negedge clk28);
      if (ps2_clk_out) break;
      cnt++;
    end
    check("req_cycles", cnt, REQ_CYC);
    check("start_bit_held", ps2_dat_out, 0);

    if (mode == M_NOCLK) begin
      cnt = 0;
      while (cnt < TIMEOUT_CYC + 100) begin
        @(negedge clk28);
        cnt++;
        if (tx_error) break;
      end
      check("timeout_cycles", cnt, TIMEOUT_CYC);
      check("timeout_lines", {ps2_clk_out, ps2_dat_out, tx_ready}, 3'b111);
    end else begin
      repeat (40) @(negedge clk28);
      for (int k = 0; k < 10; k++) begin
        dev_clk = 1'b0;
        repeat (H) @(negedge clk28);
        if (bit_q.size() == 0) check("bit_underflow", 1, 0);
        else                   check($sformatf("bit%0d", k), ps2_dat_out, bit_q.pop_front());
        if (mode == M_RESET && k == 3) begin
          rst_n = 1'b0;
          #1;
          check("reset_async", {ps2_clk_out, ps2_dat_out, tx_ready, busy, tx_done, tx_error}, 6'b111000);
          bit_q.delete();
          dev_clk = 1'b1;
          repeat (5) @(negedge clk28);
          check("reset_hold", {ps2_clk_out, ps2_dat_out, tx_ready, busy, tx_done, tx_error}, 6'b111000);
          rst_n = 1'b1;
          repeat (5) @(negedge clk28);
          return;
        end
        if (mode == M_GLITCH && k == 2) begin
          tx_data  = 8'h55;
          tx_valid = 1'b1;
        end
        if (mode == M_GLITCH && k == 6) begin
          check("ready_in_bits", {tx_ready, busy}, 2'b01);
          tx_valid = 1'b0;
        end
        dev_clk = 1'b1;
        if (mode == M_GLITCH && (k % 3) == 1) begin
          repeat (10) @(negedge clk28);
          dev_clk = 1'b0;
          repeat (3) @(negedge clk28);
          dev_clk = 1'b1;
          repeat (H - 13) @(negedge clk28);
        end else begin
          repeat (H) @(negedge clk28);
        end
      end
      if (mode != M_NACK) dev_dat = 1'b0;
      repeat (H) @(negedge clk28);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk28);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk28);
      dev_dat = 1'b1;
    end

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge clk28);
      cnt++;
    end
    check("outcome_seen", exp_q.size(), 0);
    @(negedge clk28);
    check("idle_after", {tx_ready, busy, ps2_clk_out, ps2_dat_out}, 4'b1011);
  endtask

  initial begin
    repeat (3) @(negedge clk28);
    check("reset_outputs", {ps2_clk_out, ps2_dat_out, tx_ready, busy, tx_done, tx_error}, 6'b111000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk28);

    send(8'hED, M_ACK);
    send(8'h01, M_ACK);
    send(8'h3C, M_NACK);
    send(8'hC3, M_NOCLK);
    send(8'hAA, M_GLITCH);
    send(8'h00, M_RESET);
    send(8'hF4, M_ACK);
    send(8'($urandom_range(0, 255)), M_ACK);

    repeat (20) @(negedge clk28);
    check("queues_empty", bit_q.size() + exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 28_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter FILTER, default 8, the number of cycles an input must be stable before it is accepted.
REQ-003 The block SHALL have parameter TIMEOUT_MS, default 15, the maximum duration of a transfer, measured from clock release.
REQ-004 The block SHALL have these ports, one per line:
- clk28  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ps2_clk_in  input  1  raw PS/2 clock line
- ps2_dat_in  input  1  raw PS/2 data line
- ps2_clk_out  output  1  0 = pull clock low, 1 = release
- ps2_dat_out  output  1  0 = pull data low, 1 = release
- tx_valid  input  1  request to send tx_data
- tx_data  input  8  byte to send to the device
- tx_ready  output  1  block idle, accepts request
- tx_done  output  1  1-cycle pulse: byte acknowledged by the device
- tx_error  output  1  1-cycle pulse: no ack, or timeout
- busy  output  1  transfer in progress; the PS/2 receiver ignores the bus while busy=1
REQ-005 Reset SHALL be rst_n, asynchronous, active-low; the clock SHALL be clk28.

Function
REQ-006 Input conditioning: ps2_clk_in and ps2_dat_in SHALL each pass through a 2-flop synchronizer and then a FILTER-cycle stability filter; the filtered value SHALL change only after FILTER consecutive equal synchronized samples.
REQ-007 A falling edge SHALL be detected when the filtered clock changes from 1 to 0; at most one edge SHALL be detected per filtered transition.
REQ-008 The state machine SHALL have the states IDLE, INHIBIT, REQ, BITS, ACK and WAIT_IDLE.
REQ-009 In IDLE: tx_ready=1, busy=0, both outputs released (1).
REQ-010 When tx_valid=1 in IDLE, the block SHALL:
- latch tx_data into a shift register;
- compute parity = XNOR-reduction of tx_data (odd parity);
- drive ps2_clk_out=0;
- enter INHIBIT with tx_ready=0 from the next cycle.
REQ-011 tx_valid while not in IDLE SHALL be ignored; changes to tx_data after acceptance SHALL have no effect.
REQ-012 INHIBIT SHALL hold the clock low for exactly CLK_FREQ/10000 cycles (2800, i.e. 100 us), then drive ps2_dat_out=0 (start bit) and enter REQ.
REQ-013 REQ SHALL keep the clock and data low for CLK_FREQ/1_000_000 cycles (28), then release the clock, clear bit_cnt and the timeout counter, and enter BITS.
REQ-014 In BITS, on each falling edge, ps2_dat_out SHALL present:
- bit_cnt 0..7: tx_data[bit_cnt], LSB first;
- bit_cnt 8: parity;
- bit_cnt 9: stop bit (1).
bit_cnt SHALL increment by 1 per edge; after the bit_cnt=9 edge the block SHALL enter ACK.
REQ-015 In ACK, the block SHALL sample the filtered data at the next falling edge:
- 0: acknowledge OK;
- 1: NACK, recorded as error.
It SHALL then enter WAIT_IDLE.
REQ-016 WAIT_IDLE SHALL wait until the filtered clock and data are both 1, then return to IDLE and pulse either tx_done (OK) or tx_error (NACK) for one cycle.
REQ-017 Timeout SHALL be counted from clock release in REQ. If the counter reaches CLK_FREQ/1000*TIMEOUT_MS (420000) in BITS, ACK or WAIT_IDLE, the block SHALL:
- release both outputs;
- pulse tx_error;
- go to IDLE.
The counter SHALL be at least 19 bits wide and SHALL saturate.
REQ-018 If a timeout and the WAIT_IDLE completion occur in the same cycle, the timeout SHALL take precedence: tx_error pulses and tx_done does not.
REQ-019 tx_done and tx_error SHALL never both be 1, and neither SHALL pulse more than once per accepted request.
REQ-020 busy SHALL be 1 in every state except IDLE.

Reset
REQ-021 While rst_n=0 the block SHALL hold:
- state = IDLE;
- ps2_clk_out = 1, ps2_dat_out = 1;
- tx_ready = 1, tx_done = 0, tx_error = 0, busy = 0;
- counters cleared;
- synchronizer and filter registers = 1.
REQ-022 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously), with no tx_done or tx_error pulse.

Verification
REQ-023 Send 0xED with a device model that ACKs. Required response:
- clock low for 2800 cycles, then data low;
- bits presented 1,0,1,1,0,1,1,1, parity 1, stop 1;
- ACK=0, then one tx_done pulse;
- busy=0 afterwards.
REQ-024 Send 0x01 with device ACK. Required response: parity bit 0, stop bit 1, tx_done pulses once.
REQ-025 Device holds data high at the 11th falling edge (NACK). Required response: tx_error pulses once after both lines go high; tx_done stays 0.
REQ-026 Device never clocks after release. Required response: exactly 420000 cycles after release, tx_error pulses, lines released, tx_ready=1.
REQ-027 Assert tx_valid with 0x55 during BITS of a 0xAA transfer, and apply 3-cycle glitches on the clock. Required response: the 0xAA bit pattern is unchanged, and glitches shorter than FILTER produce no extra edges.
REQ-028 Assert rst_n=0 during BITS. Required response: both outputs are 1 within the same cycle; no pulse on tx_done or tx_error; after release, an 0xF4 transfer completes normally.
